ex_dispatch_sched: RTL and testbench
====================================

// Module: ex_dispatch_sched
// PURPOSE
//  Thread-to-ALU scheduler directly upstream of the ex stage. Each cycle it decides which ready
//  threads issue onto the NUM_ALUS ALUs. It drives registered dispatch_threads/dispatch_valid, used
//  by ex the following cycle alongside the id/ex pipeline register, and acks the issued threads
//  upstream. Round-robin fairness; ALUs that raise hold stay locked to their thread.
// PARAMETERS
//  NUM_THREADS  8   hardware threads (2..8; thread id fits TID_W)
//  NUM_ALUS     4   ALUs in ex (1..NUM_THREADS)
//  TID_W        3   thread-id width, matches dispatch_threads element width
//  HOLD_MAX     64  max consecutive hold cycles per ALU before hold_err (>=1)
// PORTS
//  clk             in   1                     clock, all state on rising edge
//  rst             in   1                     synchronous reset, active-high
//  thread_ready    in   [NUM_THREADS] x 1     thread has a decoded instr ready to issue
//  thread_flush    in   [NUM_THREADS] x 1     ctrl jump/flush for thread; ineligible this cycle
//  alu_hold        in   [NUM_ALUS] x 1        ex hold2ctrl per ALU (multi-cycle op in progress)
//  issue_ack       out  [NUM_THREADS] x 1     comb: thread granted this cycle, upstream advances
//  dispatch_threads out [NUM_ALUS] x TID_W    registered thread id per ALU, to ex
//  dispatch_valid  out  [NUM_ALUS] x 1        registered: ALU carries a live instr; gates writeback
//  hold_err        out  1                     sticky: some ALU held > HOLD_MAX cycles
// BEHAVIOUR
//  Reset (rst=1 at edge): dispatch_threads[*]=0, dispatch_valid[*]=0, rr_ptr=0, lock[*]=0,
//   hold_cnt[*]=0, hold_err=0. issue_ack forced 0 while rst=1.
//  Lock: ALU i is locked next cycle iff dispatch_valid[i] & alu_hold[i] & ~thread_flush[th],
//   th=dispatch_threads[i]. A locked ALU keeps the same id with valid=1, and th is ineligible elsewhere.
//   issue_ack[th]=0 while locked. alu_hold on an ALU with dispatch_valid=0 is ignored.
//  Eligible thread t: thread_ready[t] & ~thread_flush[t] & t not held by any ALU.
//  Grant: free (unlocked) ALUs are filled in ascending ALU index. Threads are scanned from rr_ptr
//   upward mod NUM_THREADS; each eligible thread is taken at most once.
//   A free ALU with no thread gets valid=0 and id=0.
//  issue_ack[t]=1 for exactly the threads newly granted this cycle (same cycle as decision).
//  Latency: decision in cycle N -> dispatch_threads/valid visible in N+1 (one register stage).
//  rr_ptr: if >=1 grant, rr_ptr <= (last granted id + 1) mod NUM_THREADS; else unchanged.
//   Locked ALUs do not move rr_ptr.
//  Wrap: scan crosses NUM_THREADS-1 -> 0 with no bubble. Thread ids >= NUM_THREADS are never issued.
//  Flush of a locked thread: lock released the same cycle. The ALU becomes free, and th is
//   ineligible until the next cycle.
//  hold_cnt[i]: +1 per cycle ALU i is locked, saturates, cleared when the lock drops.
//   hold_cnt[i]==HOLD_MAX with lock still requested -> hold_err<=1, sticky until rst.
//   The lock is still honoured.
//  Simultaneous ready+flush on a thread: flush wins (no grant, no ack).
//  Invariant: no thread id appears on two valid ALUs in the same cycle.
//  Reset mid-hold: lock, counters and outputs cleared. Upstream must replay that thread.
// TESTING
//  T1 reset: rst=1 with all thread_ready=1 -> issue_ack=0, all valid=0; cycle after release ->
//     ack[0..3]=1; next cycle dispatch_threads={0,1,2,3}, valid=4'b1111.
//  T2 RR wrap: 8 threads all ready -> ALUs get {0,1,2,3}, then {4,5,6,7}, then {0,1,2,3};
//     rr_ptr 0->4->0.
//  T3 hold: ALU1 on thread 5, alu_hold[1]=1 for 3 cycles -> dispatch_threads[1]=5, valid[1]=1
//     for 3 more cycles; ack[5]=0; 5 never on ALU0/2/3; others keep rotating.
//  T4 sparse ready: only threads 2,6 ready, rr_ptr=3 -> ALU0=6, ALU1=2, ALU2/3 valid=0;
//     rr_ptr->3.
//  T5 flush: thread_flush[3]=1 while ALU2 locked on 3 and thread 3 ready -> lock released,
//     ack[3]=0, next cycle ALU2 gets another thread or valid=0.
//  T6 watchdog: HOLD_MAX=4, alu_hold[0] held 6 cycles -> hold_err rises after 4 locked cycles,
//     stays 1 after the hold drops, clears only on rst.

Source files
------------

// File: rtl/ex_dispatch_sched.sv
// Round-robin thread-to-ALU dispatch scheduler feeding the ex stage.
// Held ALUs stay locked to their thread; registered dispatch outputs, combinational acks.
module ex_dispatch_sched #(
  parameter int NUM_THREADS = 8,
  parameter int NUM_ALUS    = 4,
  parameter int TID_W       = 3,
  parameter int HOLD_MAX    = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_THREADS-1:0]             thread_ready,
  input  logic [NUM_THREADS-1:0]             thread_flush,
  input  logic [NUM_ALUS-1:0]                alu_hold,
  output logic [NUM_THREADS-1:0]             issue_ack,
  output logic [NUM_ALUS-1:0][TID_W-1:0]     dispatch_threads,
  output logic [NUM_ALUS-1:0]                dispatch_valid,
  output logic                               hold_err
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  logic [TID_W-1:0]                  rr_ptr_r;
  logic [NUM_ALUS-1:0][CNT_W-1:0]    hold_cnt_r;
  logic [NUM_ALUS-1:0]               lock_s;
  logic [NUM_THREADS-1:0]            held_s;
  logic [NUM_THREADS-1:0]            elig_s;
  logic [NUM_THREADS-1:0]            grant_s;
  logic [NUM_ALUS-1:0][TID_W-1:0]    next_tid_s;
  logic [NUM_ALUS-1:0]               next_valid_s;
  logic [TID_W-1:0]                  next_rr_s;

  // Lock detection: a live ALU requesting hold keeps its thread unless that thread is flushed.
  always_comb begin
    lock_s = '0;
    held_s = '0;
    for (int i = 0; i < NUM_ALUS; i++) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (dispatch_valid[i] && alu_hold[i] && (dispatch_threads[i] == TID_W'(t)) && !thread_flush[t]) begin
          lock_s[i] = 1'b1;
          held_s[t] = 1'b1;
        end else begin
          held_s[t] = held_s[t];
        end
      end
    end
  end

  assign elig_s = thread_ready & ~thread_flush & ~held_s;

  // Grant: free ALUs in ascending order take the next eligible thread scanning from rr_ptr.
  always_comb begin : grant_p
    int   idx;
    logic found;
    grant_s      = '0;
    next_valid_s = '0;
    next_tid_s   = '0;
    next_rr_s    = rr_ptr_r;
    idx          = 0;
    found        = 1'b0;
    for (int i = 0; i < NUM_ALUS; i++) begin
      found = 1'b0;
      if (lock_s[i]) begin
        next_valid_s[i] = 1'b1;
        next_tid_s[i]   = dispatch_threads[i];
      end else begin
        for (int k = 0; k < NUM_THREADS; k++) begin
          idx = int'(rr_ptr_r) + k;
          if (idx >= NUM_THREADS) begin
            idx = idx - NUM_THREADS;
          end else begin
            idx = idx;
          end
          if (!found && elig_s[IDX_W'(idx)] && !grant_s[IDX_W'(idx)]) begin
            found                  = 1'b1;
            grant_s[IDX_W'(idx)]   = 1'b1;
            next_valid_s[i]        = 1'b1;
            next_tid_s[i]          = TID_W'(idx);
            next_rr_s              = (idx == NUM_THREADS - 1) ? '0 : TID_W'(idx + 1);
          end else begin
            found = found;
          end
        end
      end
    end
  end

  assign issue_ack = rst ? '0 : grant_s;

  // Dispatch registers, round-robin pointer and hold watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      dispatch_threads <= '0;
      dispatch_valid   <= '0;
      rr_ptr_r         <= '0;
      hold_cnt_r       <= '0;
      hold_err         <= 1'b0;
    end else begin
      dispatch_threads <= next_tid_s;
      dispatch_valid   <= next_valid_s;
      rr_ptr_r         <= next_rr_s;
      for (int i = 0; i < NUM_ALUS; i++) begin
        if (lock_s[i]) begin
          if (hold_cnt_r[i] == HOLD_LIM) begin
            hold_err <= 1'b1;
          end else begin
            hold_cnt_r[i] <= hold_cnt_r[i] + CNT_W'(1);
          end
        end else begin
          hold_cnt_r[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_dispatch_sched.sv
// Directed bench for ex_dispatch_sched with hand-computed dispatch/ack patterns.
module tb_ex_dispatch_sched;

  logic             clk;
  logic             rst;
  logic [7:0]       thread_ready;
  logic [7:0]       thread_flush;
  logic [3:0]       alu_hold;
  logic [7:0]       issue_ack;
  logic [3:0][2:0]  dispatch_threads;
  logic [3:0]       dispatch_valid;
  logic             hold_err;

  int checks;
  int errors;

  ex_dispatch_sched #(
    .NUM_THREADS(8), .NUM_ALUS(4), .TID_W(3), .HOLD_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .thread_ready(thread_ready), .thread_flush(thread_flush), .alu_hold(alu_hold),
    .issue_ack(issue_ack), .dispatch_threads(dispatch_threads),
    .dispatch_valid(dispatch_valid), .hold_err(hold_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; thread_ready = 8'hFF; thread_flush = 8'h00; alu_hold = 4'h0;
    tick(); tick();
    checks++; if (issue_ack !== 8'h00) begin errors++; $display("FAIL rst_ack got %h exp %h", issue_ack, 8'h00); end
    checks++; if (dispatch_valid !== 4'h0) begin errors++; $display("FAIL rst_valid got %h exp %h", dispatch_valid, 4'h0); end
    checks++; if (dispatch_threads !== 12'h000) begin errors++; $display("FAIL rst_tid got %h exp %h", dispatch_threads, 12'h000); end
    checks++; if (hold_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp %b", hold_err, 1'b0); end
    rst = 1'b0;
    #1;
    checks++; if (issue_ack !== 8'h0F) begin errors++; $display("FAIL rel_ack got %h exp %h", issue_ack, 8'h0F); end
    tick();
    checks++; if (dispatch_threads !== {3'd3, 3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL rel_tid got %h exp %h", dispatch_threads, {3'd3, 3'd2, 3'd1, 3'd0}); end
    checks++; if (dispatch_valid !== 4'hF) begin errors++; $display("FAIL rel_valid got %h exp %h", dispatch_valid, 4'hF); end
    checks++; if (issue_ack !== 8'hF0) begin errors++; $display("FAIL rel_ack2 got %h exp %h", issue_ack, 8'hF0); end
  endtask

  task automatic test_rr_wrap();
    tick();
    checks++; if (dispatch_threads !== {3'd7, 3'd6, 3'd5, 3'd4}) begin errors++; $display("FAIL wrap_tid1 got %h exp %h", dispatch_threads, {3'd7, 3'd6, 3'd5, 3'd4}); end
    checks++; if (issue_ack !== 8'h0F) begin errors++; $display("FAIL wrap_ack got %h exp %h", issue_ack, 8'h0F); end
    tick();
    checks++; if (dispatch_threads !== {3'd3, 3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL wrap_tid2 got %h exp %h", dispatch_threads, {3'd3, 3'd2, 3'd1, 3'd0}); end
    tick();
    checks++; if (dispatch_threads !== {3'd7, 3'd6, 3'd5, 3'd4}) begin errors++; $display("FAIL wrap_tid3 got %h exp %h", dispatch_threads, {3'd7, 3'd6, 3'd5, 3'd4}); end
  endtask

  task automatic test_hold();
    logic [11:0] exp_tid [3];
    logic [7:0]  exp_ack [3];
    exp_ack[0] = 8'h07; exp_tid[0] = {3'd2, 3'd1, 3'd5, 3'd0};
    exp_ack[1] = 8'h58; exp_tid[1] = {3'd6, 3'd4, 3'd5, 3'd3};
    exp_ack[2] = 8'h83; exp_tid[2] = {3'd1, 3'd0, 3'd5, 3'd7};
    alu_hold = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (issue_ack !== exp_ack[c]) begin errors++; $display("FAIL hold_ack%0d got %h exp %h", c, issue_ack, exp_ack[c]); end
      tick();
      checks++; if (dispatch_threads !== exp_tid[c] || dispatch_valid !== 4'hF) begin errors++; $display("FAIL hold_tid%0d got %h/%h exp %h/f", c, dispatch_threads, dispatch_valid, exp_tid[c]); end
    end
    alu_hold = 4'b0000;
    #1;
    checks++; if (issue_ack !== 8'h3C) begin errors++; $display("FAIL unhold_ack got %h exp %h", issue_ack, 8'h3C); end
    checks++; if (hold_err !== 1'b0) begin errors++; $display("FAIL hold_noerr got %b exp %b", hold_err, 1'b0); end
    tick();
    checks++; if (dispatch_threads !== {3'd5, 3'd4, 3'd3, 3'd2}) begin errors++; $display("FAIL unhold_tid got %h exp %h", dispatch_threads, {3'd5, 3'd4, 3'd3, 3'd2}); end
  endtask

  task automatic test_sparse();
    thread_ready = 8'b0000_0100;
    #1;
    checks++; if (issue_ack !== 8'h04) begin errors++; $display("FAIL sp_ack1 got %h exp %h", issue_ack, 8'h04); end
    tick();
    checks++; if (dispatch_valid !== 4'b0001 || dispatch_threads !== {3'd0, 3'd0, 3'd0, 3'd2}) begin errors++; $display("FAIL sp_tid1 got %h/%h exp %h/1", dispatch_threads, dispatch_valid, {3'd0, 3'd0, 3'd0, 3'd2}); end
    thread_ready = 8'b0100_0100;
    #1;
    checks++; if (issue_ack !== 8'h44) begin errors++; $display("FAIL sp_ack2 got %h exp %h", issue_ack, 8'h44); end
    tick();
    checks++; if (dispatch_threads !== {3'd0, 3'd0, 3'd2, 3'd6}) begin errors++; $display("FAIL sp_tid2 got %h exp %h", dispatch_threads, {3'd0, 3'd0, 3'd2, 3'd6}); end
    checks++; if (dispatch_valid !== 4'b0011) begin errors++; $display("FAIL sp_valid got %h exp %h", dispatch_valid, 4'b0011); end
    tick();
    checks++; if (dispatch_threads !== {3'd0, 3'd0, 3'd2, 3'd6}) begin errors++; $display("FAIL sp_tid3 got %h exp %h", dispatch_threads, {3'd0, 3'd0, 3'd2, 3'd6}); end
  endtask

  task automatic test_flush();
    thread_ready = 8'b0000_0001;
    tick();
    thread_ready = 8'hFF;
    #1;
    checks++; if (issue_ack !== 8'h1E) begin errors++; $display("FAIL fl_ack0 got %h exp %h", issue_ack, 8'h1E); end
    tick();
    alu_hold = 4'b0100;
    #1;
    checks++; if (issue_ack !== 8'hE0) begin errors++; $display("FAIL fl_ack1 got %h exp %h", issue_ack, 8'hE0); end
    tick();
    checks++; if (dispatch_threads !== {3'd7, 3'd3, 3'd6, 3'd5}) begin errors++; $display("FAIL fl_lock got %h exp %h", dispatch_threads, {3'd7, 3'd3, 3'd6, 3'd5}); end
    thread_flush = 8'b0000_1000;
    #1;
    checks++; if (issue_ack !== 8'h17) begin errors++; $display("FAIL fl_ack2 got %h exp %h", issue_ack, 8'h17); end
    tick();
    alu_hold = 4'b0000; thread_flush = 8'h00;
    checks++; if (dispatch_threads !== {3'd4, 3'd2, 3'd1, 3'd0} || dispatch_valid !== 4'hF) begin errors++; $display("FAIL fl_tid got %h/%h exp %h/f", dispatch_threads, dispatch_valid, {3'd4, 3'd2, 3'd1, 3'd0}); end
  endtask

  task automatic test_watchdog();
    rst = 1'b1; thread_ready = 8'hFF;
    tick();
    rst = 1'b0;
    tick();
    alu_hold = 4'b0001;
    tick(); tick(); tick();
    checks++; if (hold_err !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp %b", hold_err, 1'b0); end
    tick(); tick(); tick();
    checks++; if (hold_err !== 1'b1) begin errors++; $display("FAIL wd_rise got %b exp %b", hold_err, 1'b1); end
    checks++; if (dispatch_threads[0] !== 3'd0 || dispatch_valid[0] !== 1'b1) begin errors++; $display("FAIL wd_lock got %h/%b exp 0/1", dispatch_threads[0], dispatch_valid[0]); end
    alu_hold = 4'b0000;
    tick(); tick();
    checks++; if (hold_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp %b", hold_err, 1'b1); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (hold_err !== 1'b0) begin errors++; $display("FAIL wd_clear got %b exp %b", hold_err, 1'b0); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; thread_ready = 8'h00; thread_flush = 8'h00; alu_hold = 4'h0;
    #2;
    test_reset();
    test_rr_wrap();
    test_hold();
    test_sparse();
    test_flush();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
